// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - Command FIFO and three-state issue controller for a 4-bit combinational ALU
//
// Purpose:
//   Commands (opcode + two operands) are queued in a DEPTH-entry FIFO. They are
//   issued one at a time to an external combinational ALU through registered
//   alu_* outputs. The ALU result is sampled one cycle later, and the result is
//   presented on a valid/ready output port. Results leave in acceptance order.
//
// Optional feature:
//   ALU_DIVZERO_CHECK_EN - when defined, DIV with b = 0 yields out_f = 4'hF and
//   out_err = 1. When undefined, out_err is tied low and out_f is the raw ALU result.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid, in_ready          command handshake
//   in_oc[2:0], in_a, in_b      command opcode and operands
//   alu_oc, alu_a, alu_b        registered drive to the downstream ALU
//   alu_f                       ALU result, sampled one cycle after issue
//   out_valid, out_ready        result handshake
//   out_f, out_oc, out_err      result, producing opcode, error flag
//   count                       FIFO occupancy
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_oc,
  input  logic [3:0]                   in_a,
  input  logic [3:0]                   in_b,
  output logic [2:0]                   alu_oc,
  output logic [3:0]                   alu_a,
  output logic [3:0]                   alu_b,
  input  logic [3:0]                   alu_f,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   out_f,
  output logic [2:0]                   out_oc,
  output logic                         out_err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;

  logic [2:0]    r_alu_oc;
  logic [3:0]    r_alu_a;
  logic [3:0]    r_alu_b;

  logic          r_out_valid;
  logic [3:0]    r_out_f;
  logic [2:0]    r_out_oc;
  logic [3:0]    w_res_f;

  // The full flag comes only from registered occupancy, so a pop on the same
  // edge never opens room for a push while full.
  assign in_ready = (r_count < CNT_FULL);
  assign w_push   = in_valid & in_ready;

  // Next-state and pop decision. A pop loads the FIFO head into the alu_*
  // registers, so it happens only on the way into EXEC.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        w_next_state = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (r_count != '0) begin
            w_pop        = 1'b1;
            w_next_state = EXEC;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

`ifdef ALU_DIVZERO_CHECK_EN
  localparam logic [2:0] OC_DIV = 3'b011;

  logic w_div0;
  logic r_out_err;

  assign w_div0  = (r_alu_oc == OC_DIV) && (r_alu_b == 4'd0);
  assign w_res_f = w_div0 ? 4'hF : alu_f;
  assign out_err = r_out_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_err <= 1'b0;
    end else if (r_state == EXEC) begin
      r_out_err <= w_div0;
    end
  end
`else
  assign w_res_f = alu_f;
  assign out_err = 1'b0;
`endif

  // FIFO storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {in_oc, in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_alu_oc    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_f     <= '0;
      r_out_oc    <= '0;
    end else begin
      r_state <= w_next_state;

      // DEPTH is a power of two, so pointers wrap naturally at AW bits.
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end

      if (w_pop) begin
        r_rptr                        <= r_rptr + AW'(1);
        {r_alu_oc, r_alu_a, r_alu_b}  <= r_mem[r_rptr];
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // alu_* has been stable for a full cycle in EXEC, so alu_f is settled.
      if (r_state == EXEC) begin
        r_out_valid <= 1'b1;
        r_out_f     <= w_res_f;
        r_out_oc    <= r_alu_oc;
      end else if ((r_state == DONE) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign alu_oc    = r_alu_oc;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign out_valid = r_out_valid;
  assign out_f     = r_out_f;
  assign out_oc    = r_out_oc;
  assign count     = r_count;

endmodule
